// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer: advances, branches, holds or stops each cycle.
// Optional call/return link register is built when PC_LINK_EN is defined.
module prog_ctr #(
    parameter int unsigned PW = 12,
    parameter int unsigned OW = 6,
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [PW-1:0] start_addr_i,
    input  logic          stall_i,
    input  logic          halt_i,
    input  logic          branch_i,
    input  logic          taken_i,
    input  logic [OW-1:0] target_i,
    input  logic          call_i,
    input  logic          ret_i,
    output logic [PW-1:0] prog_ctr_o,
    output logic          running_o,
    output logic          done_o,
    output logic [CW-1:0] branch_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam int unsigned ExtW = PW - OW;

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] off_ext;
    logic [PW-1:0] pc_inc;
    logic [PW-1:0] pc_rel;

    assign off_ext = {{ExtW{target_i[OW-1]}}, target_i};
    assign pc_inc  = pc_q + PW'(1);
    assign pc_rel  = pc_q + off_ext;

`ifdef PC_LINK_EN
    logic [PW-1:0] link_q, link_d;
`else
    logic unused_link;
    assign unused_link = call_i ^ ret_i;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef PC_LINK_EN
        link_d  = link_q;
`endif
        if (start_i) begin
            state_d = StRun;
            pc_d    = start_addr_i;
            cnt_d   = '0;
`ifdef PC_LINK_EN
            link_d  = '0;
`endif
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!stall_i) begin
                        if (halt_i) begin
                            state_d = StDone;
`ifdef PC_LINK_EN
                        end else if (ret_i) begin
                            pc_d = link_q;
                        end else if (call_i) begin
                            link_d = pc_inc;
                            pc_d   = pc_rel;
`endif
                        end else if (branch_i && taken_i) begin
                            pc_d = pc_rel;
                            // Saturate rather than wrap so the harness sees a lower bound.
                            if (cnt_q != {CW{1'b1}}) begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
                StIdle, StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_LINK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end
`endif

    assign prog_ctr_o   = pc_q;
    assign running_o    = (state_q == StRun);
    assign done_o       = (state_q == StDone);
    assign branch_cnt_o = cnt_q;

endmodule
